// File: rtl/pc_low.sv
// pc_low: low byte (PCL) of the 6502 program counter.
// Holds the 8-bit PCL register, which can be loaded from the ADL bus,
// incremented, or forced to a vector low byte. It drives ADL and DB through
// tri-state outputs and supplies the incrementer carry to the PC-high block.
module pc_low #(
  parameter logic [7:0] RST_VEC_L = 8'hFC,
  parameter logic [7:0] NMI_VEC_L = 8'hFA,
  parameter logic [7:0] IRQ_VEC_L = 8'hFE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] adlin,
  input  logic       adlwa,
  input  logic       inc,
  input  logic       setreset,
  input  logic       setirq,
  input  logic       setnmi,
  input  logic       adloa,
  input  logic       dboa,
  output logic [7:0] dbout,
  output logic [7:0] adlout,
  output logic       pclc
);

  logic [7:0] r_pcl;
  logic [7:0] w_src;
  logic [7:0] w_sum;
  logic       w_vec_set;
  logic [7:0] w_vec_val;
  logic [7:0] w_pcl_next;

  // Incrementer operand: the ADL bus when writing, otherwise the held value.
  // A load with inc set stores adlin+1, mirroring the ADL-to-PCL path that
  // feeds the incrementer on the real part.
  always_comb begin
    w_src = adlwa ? adlin : r_pcl;
    w_sum = w_src + {7'd0, inc};
  end

  // Vector selection; setreset outranks setnmi, which outranks setirq.
  always_comb begin
    w_vec_set = setreset | setnmi | setirq;
    if (setreset) begin
      w_vec_val = RST_VEC_L;
    end else if (setnmi) begin
      w_vec_val = NMI_VEC_L;
    end else if (setirq) begin
      w_vec_val = IRQ_VEC_L;
    end else begin
      w_vec_val = 8'h00;
    end
  end

  // Next-state mux: a vector load ignores both adlwa and inc.
  always_comb begin
    w_pcl_next = w_vec_set ? w_vec_val : w_sum;
  end

  // PCL register; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcl <= 8'h00;
    end else begin
      r_pcl <= w_pcl_next;
    end
  end

  // Carry to PC high, valid in the same cycle as the wrapping increment so
  // both halves advance on the same edge.
  always_comb begin
    pclc = inc & (w_src == 8'hFF) & ~w_vec_set & rst_n;
  end

  // Bus drivers come from the stored register, never from next-state.
  always_comb begin
    adlout = adloa ? r_pcl : 8'hzz;
    dbout  = dboa  ? r_pcl : 8'hzz;
  end

endmodule

// File: tb/tb_pc_low.sv
// tb_pc_low: directed scoreboard bench for pc_low.
// The stimulus process drives one vector per cycle and pushes the
// hand-computed outputs it expects for that cycle; a separate monitor pops
// and compares them once the combinational outputs have settled.
module tb_pc_low;

  logic       clk;
  logic       rst_n;
  logic [7:0] adlin;
  logic       adlwa;
  logic       inc;
  logic       setreset;
  logic       setirq;
  logic       setnmi;
  logic       adloa;
  logic       dboa;
  logic [7:0] dbout;
  logic [7:0] adlout;
  logic       pclc;

  pc_low dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adlin    (adlin),
    .adlwa    (adlwa),
    .inc      (inc),
    .setreset (setreset),
    .setirq   (setirq),
    .setnmi   (setnmi),
    .adloa    (adloa),
    .dboa     (dboa),
    .dbout    (dbout),
    .adlout   (adlout),
    .pclc     (pclc)
  );

  typedef struct {
    string      name;
    logic [7:0] pcl;
    logic       adl_en;
    logic       db_en;
    logic       pclc;
  } exp_t;

  exp_t q[$];
  logic tb_vld;
  logic stim_done;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A bus whose enable is low must not be driving pcl. A floating bus reads
  // as zz in a 4-state simulator; a 2-state one cannot show z, so a value
  // other than pcl is accepted as released.
  function automatic bit bus_ok(input logic [7:0] act, input logic [7:0] pcl, input logic en);
    if (en) return (act === pcl);
    return (act === 8'hzz) || (act !== pcl) || (pcl == 8'h00);
  endfunction

  task automatic step(input string nm, input logic rn, input logic wa,
                      input logic [7:0] ai, input logic ic, input logic sr,
                      input logic sn, input logic si, input logic ao,
                      input logic dob, input logic [7:0] ep, input logic ec,
                      input bit chk);
    exp_t e;
    @(negedge clk);
    rst_n    = rn;
    adlwa    = wa;
    adlin    = ai;
    inc      = ic;
    setreset = sr;
    setnmi   = sn;
    setirq   = si;
    adloa    = ao;
    dboa     = dob;
    if (chk) begin
      e.name   = nm;
      e.pcl    = ep;
      e.adl_en = ao;
      e.db_en  = dob;
      e.pclc   = ec;
      q.push_back(e);
    end
    tb_vld = chk;
  endtask

  // Monitor: compares the settled outputs of each flagged cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (tb_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s: no expectation queued", "scoreboard");
        end else begin
          e = q.pop_front();
          if (!bus_ok(adlout, e.pcl, e.adl_en) || !bus_ok(dbout, e.pcl, e.db_en)
              || (pclc !== e.pclc)) begin
            errors++;
            $display("FAIL %s: adlout=%h dbout=%h pclc=%b, required pcl=%h adl_en=%b db_en=%b pclc=%b",
                     e.name, adlout, dbout, pclc, e.pcl, e.adl_en, e.db_en, e.pclc);
          end
        end
      end
    end
  end

  // Stimulus: name, rst_n, adlwa, adlin, inc, setreset, setnmi, setirq,
  // adloa, dboa, expected pcl on the buses, expected pclc, check flag.
  initial begin
    tb_vld = 1'b0; stim_done = 1'b0; errors = 0; checks = 0;
    rst_n = 1'b0; adlwa = 1'b0; adlin = 8'h00; inc = 1'b0;
    setreset = 1'b0; setnmi = 1'b0; setirq = 1'b0; adloa = 1'b0; dboa = 1'b0;

    step("init_rst",   0,0,8'h00,0, 0,0,0, 0,0, 8'h00,0, 1);
    step("rst_adl",    1,0,8'h00,0, 0,0,0, 1,0, 8'h00,0, 1);
    step("rst_db",     1,0,8'h00,0, 0,0,0, 0,1, 8'h00,0, 1);
    step("load_3C",    1,1,8'h3C,0, 0,0,0, 1,0, 8'h00,0, 1);
    step("inc_a",      1,0,8'h00,1, 0,0,0, 1,0, 8'h3C,0, 1);
    step("inc_b",      1,0,8'h00,1, 0,0,0, 1,0, 8'h3D,0, 1);
    step("inc_c",      1,0,8'h00,1, 0,0,0, 1,0, 8'h3E,0, 1);
    step("hold_3F_db", 1,0,8'h00,0, 0,0,0, 0,1, 8'h3F,0, 1);
    step("ldinc_FF",   1,1,8'hFF,1, 0,0,0, 1,0, 8'h3F,1, 1);
    step("wrap_00",    1,0,8'h00,1, 0,0,0, 1,0, 8'h00,0, 1);
    step("hold_01",    1,0,8'h00,0, 0,0,0, 1,0, 8'h01,0, 1);
    step("load_FF",    1,1,8'hFF,0, 0,0,0, 1,0, 8'h01,0, 1);
    step("inc_FF",     1,0,8'h00,1, 0,0,0, 1,0, 8'hFF,1, 1);
    step("after_wrap", 1,0,8'h00,0, 0,0,0, 1,0, 8'h00,0, 1);
    step("load_FF2",   1,1,8'hFF,0, 0,0,0, 1,0, 8'h00,0, 1);
    step("noinc_FF",   1,0,8'h00,0, 0,0,0, 1,0, 8'hFF,0, 1);
    step("held_FF",    1,0,8'h00,1, 1,0,0, 1,0, 8'hFF,0, 1);
    step("set_irq",    1,0,8'h00,1, 0,0,1, 1,0, 8'hFC,0, 1);
    step("set_nmi",    1,0,8'h00,1, 0,1,0, 1,0, 8'hFE,0, 1);
    step("set_all",    1,0,8'h00,1, 1,1,1, 1,0, 8'hFA,0, 1);
    step("set_nmiirq", 1,0,8'h00,1, 0,1,1, 1,0, 8'hFC,0, 1);
    step("load_55",    1,1,8'h55,0, 0,0,0, 1,0, 8'hFA,0, 1);
    step("rst_prio",   0,1,8'hFF,1, 1,0,0, 1,1, 8'h55,0, 1);
    step("both_00",    1,0,8'h00,0, 0,0,0, 1,1, 8'h00,0, 1);
    step("ldinc_10",   1,1,8'h10,1, 0,0,0, 0,1, 8'h00,0, 1);
    step("hold_11",    1,0,8'h00,0, 0,0,0, 1,0, 8'h11,0, 1);
    step("idle",       1,0,8'h00,0, 0,0,0, 0,0, 8'h00,0, 0);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expectations left, required 0", "drain", q.size());
    end
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL %s: time limit reached, errors=%0d checks=%0d", "watchdog", errors, checks);
      $fatal(1, "watchdog");
    end
  end

endmodule
